// File: rtl/sync_box_pkg.sv
// Shared types and helpers for the N-core SyncBox arbiter/reservation unit.
package sync_box_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        LOCK  = 2'b10
    } state_e;

    localparam logic [1:0] IT_PLAIN = 2'b00;
    localparam logic [1:0] IT_LL    = 2'b01;
    localparam logic [1:0] IT_SC    = 2'b10;
    localparam logic [1:0] IT_RMW   = 2'b11;

    // Word-granular address compare: ignores the byte offset bits [1:0].
    function automatic logic word_match(input logic [63:0] a, input logic [63:0] b, input int aw);
        logic [63:0] mask;
        mask = ~(~64'd0 << aw) & ~64'h3;
        return ((a ^ b) & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/sync_box_n_arb.sv
// Combinational round-robin pick: first eligible core after 'last', wrapping.
module rr_arbiter_n #(
    parameter int N_CORES = 2,
    parameter int ID_W    = $clog2(N_CORES)
) (
    input  logic [N_CORES-1:0] eligible,
    input  logic [ID_W-1:0]    last,
    output logic [N_CORES-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_v
);

    // Scan from last+1 so the most recent winner has the lowest priority.
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            hit;
        gnt    = '0;
        gnt_id = '0;
        gnt_v  = 1'b0;
        idx    = '0;
        hit    = 1'b0;
        for (int i = 1; i <= N_CORES; i++) begin
            idx      = ID_W'((int'(last) + i) % N_CORES);
            hit      = eligible[idx] & ~gnt_v;
            gnt[idx] = gnt[idx] | hit;
            gnt_id   = hit ? idx : gnt_id;
            gnt_v    = gnt_v | hit;
        end
    end

endmodule

// File: rtl/sync_box_n.sv
// N-core SyncBox: round-robin bus grant plus per-core LL/SC reservation table.
// Optional watchdog enabled by defining SYNC_BOX_WATCHDOG_EN.
module sync_box_n
    import sync_box_pkg::*;
#(
    parameter int N_CORES = 2,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = $clog2(N_CORES),
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        req,
    input  logic [N_CORES-1:0]        in_init,
    input  logic [N_CORES-1:0]        trigger,
    input  logic [2*N_CORES-1:0]      instr_type,
    input  logic [N_CORES-1:0]        mw,
    input  logic [ADDR_W*N_CORES-1:0] mar,
    input  logic [N_CORES-1:0]        mem_complete,
    output logic [N_CORES-1:0]        pass,
    output logic [N_CORES-1:0]        success,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      err
);

    state_e              state_q, state_d;
    logic [N_CORES-1:0]  pass_q, pass_d;
    logic [N_CORES-1:0]  success_q, success_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                busy_q, busy_d;
    logic [N_CORES-1:0]  resv_v_q, resv_v_d;
    logic [ADDR_W-1:0]   resv_a_q [N_CORES];
    logic [ADDR_W-1:0]   resv_a_d [N_CORES];

    logic [1:0]          type_s [N_CORES];
    logic [ADDR_W-1:0]   mar_s  [N_CORES];
    logic [N_CORES-1:0]  eligible_s, arb_gnt_s;
    logic [ID_W-1:0]     arb_id_s;
    logic                arb_v_s;
    logic                busy_s, g_done_s, g_trig_s, g_write_s, abort_s, release_s;
    logic                wd_fire_s;
    logic [1:0]          g_type_s;
    logic [ADDR_W-1:0]   g_mar_s;

    for (genvar c = 0; c < N_CORES; c++) begin : g_unpack
        assign type_s[c] = instr_type[2*c +: 2];
        assign mar_s[c]  = mar[ADDR_W*c +: ADDR_W];
    end

    assign eligible_s = req & ~in_init;
    assign busy_s     = (state_q != IDLE);
    assign g_type_s   = type_s[grant_id_q];
    assign g_mar_s    = mar_s[grant_id_q];
    assign g_done_s   = busy_s & mem_complete[grant_id_q];
    assign g_trig_s   = (state_q == GRANT) & trigger[grant_id_q];
    // An SC only writes memory if it succeeded, so only then may it break others' links.
    assign g_write_s  = g_done_s & mw[grant_id_q] & ((g_type_s != IT_SC) | success_q[grant_id_q]);
    assign abort_s    = (busy_s & in_init[grant_id_q]) | wd_fire_s;

    rr_arbiter_n #(.N_CORES(N_CORES), .ID_W(ID_W)) u_arb (
        .eligible (eligible_s),
        .last     (last_q),
        .gnt      (arb_gnt_s),
        .gnt_id   (arb_id_s),
        .gnt_v    (arb_v_s)
    );

    // Grant FSM next-state and registered outputs.
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        success_d  = success_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        release_s  = 1'b0;
        case (state_q)
            IDLE: begin
                pass_d     = arb_gnt_s;
                grant_id_d = arb_id_s;
                last_d     = arb_v_s ? arb_id_s : last_q;
                state_d    = arb_v_s ? GRANT : IDLE;
            end
            GRANT: begin
                if (g_trig_s) begin
                    case (g_type_s)
                        IT_SC:         success_d[grant_id_q] = resv_v_q[grant_id_q] &
                                           word_match(64'(resv_a_q[grant_id_q]), 64'(g_mar_s), ADDR_W);
                        IT_LL, IT_RMW: success_d[grant_id_q] = 1'b1;
                        default:       success_d[grant_id_q] = success_q[grant_id_q];
                    endcase
                end else begin
                    success_d = success_q;
                end
                if (g_done_s) begin
                    if (g_type_s == IT_RMW) begin
                        state_d = LOCK;
                    end else begin
                        release_s = 1'b1;
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            LOCK:    release_s = g_done_s;
            default: release_s = 1'b1;
        endcase
        if (release_s || abort_s) begin
            state_d    = IDLE;
            pass_d     = '0;
            success_d  = '0;
            grant_id_d = '0;
        end else begin
            state_d = state_d;
        end
        busy_d = (state_d != IDLE);
    end

    // Reservation table next-state; in_init clears last so it wins over a same-cycle set.
    always_comb begin
        resv_v_d = resv_v_q;
        resv_a_d = resv_a_q;
        if (g_done_s) begin
            case (g_type_s)
                IT_LL: begin
                    resv_v_d[grant_id_q] = 1'b1;
                    resv_a_d[grant_id_q] = g_mar_s;
                end
                IT_SC:   resv_v_d[grant_id_q] = 1'b0;
                default: resv_v_d[grant_id_q] = resv_v_q[grant_id_q];
            endcase
        end else begin
            resv_v_d = resv_v_q;
        end
        for (int k = 0; k < N_CORES; k++) begin
            resv_v_d[k] = resv_v_d[k] & ~(g_write_s && (k != int'(grant_id_q)) &&
                          word_match(64'(resv_a_q[k]), 64'(g_mar_s), ADDR_W));
        end
        resv_v_d[grant_id_q] = resv_v_d[grant_id_q] & ~wd_fire_s;
        resv_v_d = resv_v_d & ~in_init;
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pass_q     <= '0;
            success_q  <= '0;
            grant_id_q <= '0;
            last_q     <= ID_W'(N_CORES - 1);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            success_q  <= success_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
        end
    end

    // Reservation registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resv_v_q <= '0;
            for (int k = 0; k < N_CORES; k++) begin
                resv_a_q[k] <= '0;
            end
        end else begin
            resv_v_q <= resv_v_d;
            for (int k = 0; k < N_CORES; k++) begin
                resv_a_q[k] <= resv_a_d[k];
            end
        end
    end

`ifdef SYNC_BOX_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    // Cycles the current owner has gone without a completion; fires on the TIMEOUT-th.
    always_comb begin
        wd_d      = '0;
        err_d     = err_q;
        wd_fire_s = 1'b0;
        if (busy_s && !g_done_s) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                wd_fire_s = 1'b1;
                err_d     = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog counter and sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_fire_s = 1'b0;
    assign err       = 1'b0;
`endif

    assign pass     = pass_q;
    assign success  = success_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sync_box_n.sv
// Bench for sync_box_n (N=4): directed transactions against a cycle-level behavioural model.
// Watchdog expectations follow SYNC_BOX_WATCHDOG_EN.
module tb_sync_box_n;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int IDW = 2;
    localparam int TO  = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, in_init, trigger, mw, mem_complete;
    logic [2*N-1:0]  instr_type;
    logic [AW*N-1:0] mar;
    logic [N-1:0]    pass, success;
    logic [IDW-1:0]  grant_id;
    logic            busy, err;

    logic [1:0]      it_a  [N];
    logic [AW-1:0]   mar_a [N];

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    assign instr_type = {it_a[3], it_a[2], it_a[1], it_a[0]};
    assign mar        = {mar_a[3], mar_a[2], mar_a[1], mar_a[0]};

    sync_box_n #(.N_CORES(N), .ADDR_W(AW), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .in_init      (in_init),
        .trigger      (trigger),
        .instr_type   (instr_type),
        .mw           (mw),
        .mar          (mar),
        .mem_complete (mem_complete),
        .pass         (pass),
        .success      (success),
        .grant_id     (grant_id),
        .busy         (busy),
        .err          (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_owner;
    bit           m_locked;
    int           m_last;
    logic [N-1:0] m_succ;
    bit           m_rv [N];
    logic [AW-1:0] m_ra [N];
    bit           m_err;
    int           m_wd;

    function automatic bit same_word(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    always @(posedge clk) begin : model
        if (!reset) begin
            m_owner = -1; m_locked = 1'b0; m_last = N - 1; m_succ = '0; m_err = 1'b0; m_wd = 0;
            for (int k = 0; k < N; k++) m_rv[k] = 1'b0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (m_owner < 0 && req[c] && !in_init[c]) begin
                    m_owner = c;
                    m_last  = c;
                end
            end
            m_wd = 0;
        end else begin
            int g;
            bit rel;
            logic [N-1:0] nsucc;
            g = m_owner; rel = 1'b0; nsucc = m_succ;
            if (!m_locked && trigger[g]) begin
                if (it_a[g] == 2'b10) nsucc[g] = m_rv[g] && same_word(m_ra[g], mar_a[g]);
                if (it_a[g] == 2'b01 || it_a[g] == 2'b11) nsucc[g] = 1'b1;
            end
            if (mem_complete[g]) begin
                if (mw[g] && (it_a[g] != 2'b10 || m_succ[g]))
                    for (int k = 0; k < N; k++)
                        if (k != g && same_word(m_ra[k], mar_a[g])) m_rv[k] = 1'b0;
                if (it_a[g] == 2'b01) begin m_rv[g] = 1'b1; m_ra[g] = mar_a[g]; end
                if (it_a[g] == 2'b10) m_rv[g] = 1'b0;
                if (it_a[g] == 2'b11 && !m_locked) m_locked = 1'b1;
                else rel = 1'b1;
                m_wd = 0;
            end else begin
                m_wd++;
`ifdef SYNC_BOX_WATCHDOG_EN
                if (m_wd >= TO) begin rel = 1'b1; m_err = 1'b1; m_rv[g] = 1'b0; end
`endif
            end
            if (in_init[g]) rel = 1'b1;
            m_succ = nsucc;
            if (rel) begin m_owner = -1; m_locked = 1'b0; m_succ = '0; m_wd = 0; end
        end
        for (int k = 0; k < N; k++) if (in_init[k]) m_rv[k] = 1'b0;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin : compare
        logic [N-1:0] ep;
        if (cmp_en) begin
            ep = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check("model_pass", pass, ep);
            check("model_success", success, m_succ);
            check("model_grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
            check("model_busy", busy, m_owner >= 0);
            check("model_err", err, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output int id, output int dead);
        dead = 0;
        while (pass == 4'b0000 && dead < 40) begin
            dead++;
            @(negedge clk);
        end
        if (pass == 4'b0000) check("grant_timeout", 64'd0, 64'd1);
        id = int'(grant_id);
    endtask

    task automatic complete(input int c);
        mem_complete[c] = 1'b1;
        @(negedge clk);
        mem_complete[c] = 1'b0;
    endtask

    task automatic txn(input int c, input logic [1:0] t, input logic w, input logic [31:0] a,
                       output logic s);
        int id, dead;
        it_a[c] = t; mw[c] = w; mar_a[c] = a; req[c] = 1'b1;
        wait_grant(id, dead);
        check("txn_core", id, c);
        req[c] = 1'b0;
        trigger[c] = 1'b1;
        @(negedge clk);
        trigger[c] = 1'b0;
        s = success[c];
        complete(c);
        if (t == 2'b11) begin
            cyc(1);
            complete(c);
        end
        cyc(1);
        it_a[c] = 2'b00; mw[c] = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin : stim
        int   id, dead;
        logic s;
        int   exp_order [5] = '{0, 1, 2, 3, 0};

        reset = 1'b0; req = '0; in_init = '0; trigger = '0; mw = '0; mem_complete = '0;
        for (int k = 0; k < N; k++) begin it_a[k] = 2'b00; mar_a[k] = '0; end
        cyc(2);
        check("reset_pass", pass, 0);
        check("reset_success", success, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        cmp_en = 1'b1;
        reset  = 1'b1;

        // Round-robin with all cores requesting, 3-cycle transactions.
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(id, dead);
            check("rr_order", id, exp_order[n]);
            if (n > 0) check("rr_dead_cycles", dead, 1);
            cyc(2);
            if (n == 4) req = '0;
            complete(id);
        end
        cyc(1);

        // LL broken by another core's write to the same word.
        txn(0, 2'b01, 1'b0, 32'h100, s); check("ll_success", s, 1);
        txn(1, 2'b00, 1'b1, 32'h102, s);
        txn(0, 2'b10, 1'b1, 32'h100, s); check("sc_after_conflict", s, 0);
        txn(0, 2'b10, 1'b1, 32'h100, s); check("sc_resv_consumed", s, 0);

        // Write to a different word keeps the link; successful SC breaks core2's link.
        txn(0, 2'b01, 1'b0, 32'h100, s);
        txn(2, 2'b01, 1'b0, 32'h100, s);
        txn(1, 2'b00, 1'b1, 32'h104, s);
        txn(0, 2'b10, 1'b1, 32'h100, s); check("sc_success", s, 1);
        txn(2, 2'b10, 1'b1, 32'h100, s); check("core2_link_broken", s, 0);

        // Locked RMW holds the bus across two completions while core 0 waits.
        it_a[1] = 2'b11; mw[1] = 1'b1; mar_a[1] = 32'h300; req[1] = 1'b1;
        wait_grant(id, dead);
        check("rmw_core", id, 1);
        req[1] = 1'b0; req[0] = 1'b1;
        trigger[1] = 1'b1;
        @(negedge clk);
        trigger[1] = 1'b0;
        check("rmw_success", success, 4'b0010);
        complete(1);
        check("rmw_lock_hold", pass, 4'b0010);
        cyc(2);
        check("rmw_lock_hold2", pass, 4'b0010);
        complete(1);
        check("rmw_release", pass, 4'b0000);
        cyc(1);
        check("rmw_next_grant", pass, 4'b0001);
        req[0] = 1'b0;
        complete(0);
        cyc(1);
        it_a[1] = 2'b00; mw[1] = 1'b0;

        // in_init excludes a requester and kills its reservation.
        txn(2, 2'b01, 1'b0, 32'h200, s);
        in_init[2] = 1'b1; req[2] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cyc(1);
            check("init_no_grant", pass[2], 0);
        end
        in_init[2] = 1'b0; req[2] = 1'b0;
        cyc(1);
        txn(2, 2'b10, 1'b1, 32'h200, s); check("init_resv_cleared", s, 0);

        // in_init rising on the granted core releases it.
        req[3] = 1'b1;
        wait_grant(id, dead);
        check("init_rel_core", id, 3);
        req[3] = 1'b0; in_init[3] = 1'b1;
        cyc(1);
        check("init_release", pass, 4'b0000);
        in_init[3] = 1'b0;
        cyc(1);

        // Grant with no completion: watchdog release, or indefinite hold.
        txn(0, 2'b01, 1'b0, 32'h400, s);
        req[3] = 1'b1;
        wait_grant(id, dead);
        check("stall_core", id, 3);
        req[3] = 1'b0;
`ifdef SYNC_BOX_WATCHDOG_EN
        cyc(TO - 1);
        check("wd_before_fire", pass, 4'b1000);
        cyc(1);
        check("wd_pass_dropped", pass, 4'b0000);
        check("wd_err_set", err, 1);
        cyc(3);
        check("wd_err_sticky", err, 1);
`else
        cyc(3 * TO);
        check("hold_no_watchdog", pass, 4'b1000);
        check("err_tied_low", err, 0);
`endif
        // Reset mid-transaction drops grant, error and reservations.
        reset = 1'b0;
        cyc(1);
        check("reset2_pass", pass, 4'b0000);
        check("reset2_err", err, 0);
        reset = 1'b1;
        cyc(1);
        txn(0, 2'b10, 1'b1, 32'h400, s); check("reset_drops_resv", s, 0);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : global_bound
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
